// File: rtl/r5p_gpr_ctl_pkg.sv
// Shared types for the GPR controller: FSM states, the debug request word and a port-arbitration helper.
// Request fields are sized for the widest supported register file (RV32I: 32 x 32-bit).
package r5p_gpr_ctl_pkg;

  localparam int unsigned R5P_AW   = 5;
  localparam int unsigned R5P_XLEN = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } gpr_st_e;

  typedef struct packed {
    logic                wr;
    logic [R5P_AW-1:0]   adr;
    logic [R5P_XLEN-1:0] wdt;
  } dbg_req_t;

  // A debug request only needs the one port its direction uses: writes take rd, reads take rs1.
  function automatic logic dbg_port_free(input logic wr, input logic c_e_rd, input logic c_e_rs1);
    return wr ? ~c_e_rd : ~c_e_rs1;
  endfunction

endpackage

// File: rtl/r5p_gpr_ctl_if.sv
// Debug-module request/response channel into the GPR controller.
// Request is valid/ready; the read response is a one-cycle pulse with no backpressure.
interface r5p_gpr_ctl_if;
  import r5p_gpr_ctl_pkg::*;

  logic                dbg_vld;
  logic                dbg_rdy;
  dbg_req_t            dbg_req;
  logic                dbg_rsp;
  logic [R5P_XLEN-1:0] dbg_rdt;

  modport master (
    output dbg_vld,
    output dbg_req,
    input  dbg_rdy,
    input  dbg_rsp,
    input  dbg_rdt
  );

  modport slave (
    input  dbg_vld,
    input  dbg_req,
    output dbg_rdy,
    output dbg_rsp,
    output dbg_rdt
  );

endinterface

// File: rtl/r5p_gpr_clr.sv
// Post-reset clear sequencer (built only with R5P_GPR_CTL_CLEAR_EN): walks cnt over every GPR address once.
// last is high while the final address is presented; the counter then freezes until the next reset.
module r5p_gpr_clr #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] cnt,
  output logic          last
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = ~done_q & (&cnt_q);

endmodule

// File: rtl/r5p_gpr_ctl.sv
// Shares the 2R/1W GPR between core (always wins) and debug (idle slots only); zero-fills the GPR after reset when R5P_GPR_CTL_CLEAR_EN is defined.
// Debug write commits at the accept edge, debug read data returns 1 cycle after accept; debug waits on dbg_rdy, dbg_rsp has no backpressure.
module r5p_gpr_ctl
  import r5p_gpr_ctl_pkg::*;
#(
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en0,
  output logic            stall,
  // core side
  input  logic            c_e_rs1,
  input  logic            c_e_rs2,
  input  logic            c_e_rd,
  input  logic [AW-1:0]   c_a_rs1,
  input  logic [AW-1:0]   c_a_rs2,
  input  logic [AW-1:0]   c_a_rd,
  input  logic [XLEN-1:0] c_d_rd,
  output logic [XLEN-1:0] c_d_rs1,
  output logic [XLEN-1:0] c_d_rs2,
  // debug side
  r5p_gpr_ctl_if.slave    dbg,
  // register file side
  output logic            g_en0,
  output logic            g_e_rs1,
  output logic            g_e_rs2,
  output logic            g_e_rd,
  output logic [AW-1:0]   g_a_rs1,
  output logic [AW-1:0]   g_a_rs2,
  output logic [AW-1:0]   g_a_rd,
  output logic [XLEN-1:0] g_d_rd,
  input  logic [XLEN-1:0] g_d_rs1,
  input  logic [XLEN-1:0] g_d_rs2
);

  logic [AW-1:0] clr_cnt;
  logic          clr_last;

`ifdef R5P_GPR_CTL_CLEAR_EN
  localparam gpr_st_e ST_RESET  = ST_CLEAR;
  localparam logic    STALL_RST = 1'b1;

  r5p_gpr_clr #(
    .AW (AW)
  ) u_clr (
    .clk  (clk),
    .rst  (rst),
    .cnt  (clr_cnt),
    .last (clr_last)
  );
`else
  localparam gpr_st_e ST_RESET  = ST_RUN;
  localparam logic    STALL_RST = 1'b0;

  assign clr_cnt  = '0;
  assign clr_last = 1'b0;
`endif

  gpr_st_e         state_q, state_d;
  logic            stall_q, stall_d;
  logic            rsp_q, rsp_d;
  logic [XLEN-1:0] rdt_q, rdt_d;

  logic            dbg_wr;
  logic [AW-1:0]   dbg_adr;
  logic [XLEN-1:0] dbg_wdt;
  logic            live;
  logic            run;
  logic            dbg_wr_acc;
  logic            dbg_rd_acc;

  assign dbg_wr  = dbg.dbg_req.wr;
  assign dbg_adr = dbg.dbg_req.adr[AW-1:0];
  assign dbg_wdt = dbg.dbg_req.wdt[XLEN-1:0];

  // Nothing reaches the register file or the debug port while reset is held.
  assign live = ~rst;
  assign run  = (state_q == ST_RUN);

  assign dbg_wr_acc = live & run & dbg.dbg_vld &  dbg_wr & ~c_e_rd;
  assign dbg_rd_acc = live & run & dbg.dbg_vld & ~dbg_wr & ~c_e_rs1;

  assign dbg.dbg_rdy = live & run & dbg_port_free(dbg_wr, c_e_rd, c_e_rs1);

  always_comb begin
    g_a_rs1 = c_e_rs1 ? c_a_rs1 : dbg_adr;
    g_a_rs2 = c_a_rs2;
    if (state_q == ST_CLEAR) begin
      g_en0   = 1'b1;
      g_e_rs1 = 1'b0;
      g_e_rs2 = 1'b0;
      g_e_rd  = live;
      g_a_rd  = clr_cnt;
      g_d_rd  = '0;
    end else begin
      g_en0   = en0;
      g_e_rs1 = live & (c_e_rs1 | dbg_rd_acc);
      g_e_rs2 = live & c_e_rs2;
      g_e_rd  = live & (c_e_rd | dbg_wr_acc);
      g_a_rd  = c_e_rd ? c_a_rd : dbg_adr;
      g_d_rd  = c_e_rd ? c_d_rd : dbg_wdt;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    if ((state_q == ST_CLEAR) && clr_last) begin
      state_d = ST_RUN;
      stall_d = 1'b0;
    end
    rsp_d = dbg_rd_acc;
    rdt_d = dbg_rd_acc ? g_d_rs1 : rdt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      stall_q <= STALL_RST;
      rsp_q   <= 1'b0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      rsp_q   <= rsp_d;
      rdt_q   <= rdt_d;
    end
  end

  assign stall       = stall_q;
  assign dbg.dbg_rsp = rsp_q;
  assign dbg.dbg_rdt = R5P_XLEN'(rdt_q);

  // Write-to-read bypass lives inside the GPR, so core read data passes straight through.
  assign c_d_rs1 = g_d_rs1;
  assign c_d_rs2 = g_d_rs2;

endmodule

// File: tb/tb_r5p_gpr_ctl.sv
// Bench for r5p_gpr_ctl: behavioural GPR, register-file reference model and a debug-response scoreboard.
module tb_r5p_gpr_ctl;
  import r5p_gpr_ctl_pkg::*;

  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NR   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            en0;
  logic            stall;
  logic            c_e_rs1, c_e_rs2, c_e_rd;
  logic [AW-1:0]   c_a_rs1, c_a_rs2, c_a_rd;
  logic [XLEN-1:0] c_d_rd, c_d_rs1, c_d_rs2;
  logic            g_en0, g_e_rs1, g_e_rs2, g_e_rd;
  logic [AW-1:0]   g_a_rs1, g_a_rs2, g_a_rd;
  logic [XLEN-1:0] g_d_rd, g_d_rs1, g_d_rs2;

  r5p_gpr_ctl_if dbg ();

  r5p_gpr_ctl #(.AW(AW), .XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .en0     (en0),
    .stall   (stall),
    .c_e_rs1 (c_e_rs1),
    .c_e_rs2 (c_e_rs2),
    .c_e_rd  (c_e_rd),
    .c_a_rs1 (c_a_rs1),
    .c_a_rs2 (c_a_rs2),
    .c_a_rd  (c_a_rd),
    .c_d_rd  (c_d_rd),
    .c_d_rs1 (c_d_rs1),
    .c_d_rs2 (c_d_rs2),
    .dbg     (dbg),
    .g_en0   (g_en0),
    .g_e_rs1 (g_e_rs1),
    .g_e_rs2 (g_e_rs2),
    .g_e_rd  (g_e_rd),
    .g_a_rs1 (g_a_rs1),
    .g_a_rs2 (g_a_rs2),
    .g_a_rd  (g_a_rd),
    .g_d_rd  (g_d_rd),
    .g_d_rs1 (g_d_rs1),
    .g_d_rs2 (g_d_rs2)
  );

  // Distributed-RAM style GPR: async read, sync write, x0 writes need g_en0; scrambled to mimic no reset.
  logic [XLEN-1:0] gpr [NR];
  logic            scramble = 1'b1;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NR; i++) gpr[i] <= $urandom | 32'h1;
    end else if (g_e_rd && (g_a_rd != '0 || g_en0)) begin
      gpr[g_a_rd] <= g_d_rd;
    end
  end
  assign g_d_rs1 = gpr[g_a_rs1];
  assign g_d_rs2 = gpr[g_a_rs2];

  // Reference register contents; ref_ok marks registers whose value is defined.
  logic [XLEN-1:0] ref_mem [NR];
  bit              ref_ok  [NR];

  typedef struct {
    bit              chk;
    logic [XLEN-1:0] val;
    int              due;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int neg_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    neg_n++;
    if (dbg.dbg_rsp === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("dbg_rsp_spurious", dbg.dbg_rsp, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("dbg_rsp_latency", neg_n, e.due);
        if (e.chk) chk("dbg_rdt", dbg.dbg_rdt, e.val);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= neg_n) begin
      e = sbq.pop_front();
      chk("dbg_rsp_missing", dbg.dbg_rsp, 1'b1);
    end
  end

  task automatic core_idle();
    c_e_rs1 = 1'b0; c_e_rs2 = 1'b0; c_e_rd = 1'b0;
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    if (a != '0 || en0) begin
      ref_mem[a] = d;
      ref_ok[a]  = 1'b1;
    end
  endtask

  // One RUN cycle: check at negedge, then book the edge's effects into the model.
  task automatic tick(output bit acc);
    bit prdy;
    @(negedge clk);
    prdy = dbg.dbg_req.wr ? !c_e_rd : !c_e_rs1;
    chk("dbg_rdy", dbg.dbg_rdy, prdy);
    chk("stall_run", stall, 1'b0);
    if (c_e_rs1 && ref_ok[c_a_rs1]) chk("c_d_rs1", c_d_rs1, ref_mem[c_a_rs1]);
    if (c_e_rs2 && ref_ok[c_a_rs2]) chk("c_d_rs2", c_d_rs2, ref_mem[c_a_rs2]);
    acc = dbg.dbg_vld && prdy;
    @(posedge clk);
    if (acc && !dbg.dbg_req.wr)
      sbq.push_back('{chk: ref_ok[dbg.dbg_req.adr], val: ref_mem[dbg.dbg_req.adr], due: neg_n + 1});
    if (c_e_rd) ref_write(c_a_rd, c_d_rd);
    else if (acc && dbg.dbg_req.wr) ref_write(dbg.dbg_req.adr, dbg.dbg_req.wdt);
    #1;
  endtask

  task automatic dbg_op(input bit wr, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bit acc = 1'b0;
    int n   = 0;
    dbg.dbg_vld = 1'b1;
    dbg.dbg_req.wr = wr; dbg.dbg_req.adr = a; dbg.dbg_req.wdt = d;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("dbg_op_timeout", dbg.dbg_rdy, 1'b1);
    dbg.dbg_vld = 1'b0;
  endtask

  task automatic clear_phase(input int n);
    for (int k = 0; k < n; k++) begin
      c_e_rs1 = 1'($urandom); c_e_rs2 = 1'($urandom); c_e_rd = 1'($urandom);
      c_a_rd = AW'($urandom); c_d_rd = $urandom; en0 = 1'($urandom);
      dbg.dbg_vld = 1'b1;
      dbg.dbg_req.wr = 1'($urandom); dbg.dbg_req.adr = AW'($urandom); dbg.dbg_req.wdt = $urandom;
      @(negedge clk);
      chk("clr_g_e_rd", g_e_rd, 1'b1);
      chk("clr_g_a_rd", g_a_rd, AW'(k));
      chk("clr_g_d_rd", g_d_rd, 0);
      chk("clr_g_en0", g_en0, 1'b1);
      chk("clr_stall", stall, 1'b1);
      chk("clr_dbg_rdy", dbg.dbg_rdy, 1'b0);
      chk("clr_g_e_rs1", g_e_rs1, 1'b0);
      chk("clr_g_e_rs2", g_e_rs2, 1'b0);
      @(posedge clk); #1;
    end
    dbg.dbg_vld = 1'b0;
    core_idle();
  endtask

  task automatic after_reset();
`ifdef R5P_GPR_CTL_CLEAR_EN
    clear_phase(NR);
    chk("stall_fall_edge", stall, 1'b0);
    for (int i = 0; i < NR; i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b1;
    end
`else
    @(negedge clk);
    chk("off_stall", stall, 1'b0);
    chk("off_dbg_rdy_idle", dbg.dbg_rdy, 1'b1);
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bit acc;
    en0 = 1'b1;
    c_e_rs1 = 1'b1; c_e_rs2 = 1'b1; c_e_rd = 1'b1;
    c_a_rs1 = '0; c_a_rs2 = '0; c_a_rd = 5'd3; c_d_rd = 32'h55;
    dbg.dbg_vld = 1'b1;
    dbg.dbg_req.wr = 1'b0; dbg.dbg_req.adr = 5'd1; dbg.dbg_req.wdt = '0;
    for (int i = 0; i < NR; i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end

    // Reset state, with core and debug both requesting.
    repeat (2) @(posedge clk);
    #1 scramble = 1'b0;
    @(negedge clk);
`ifdef R5P_GPR_CTL_CLEAR_EN
    chk("rst_stall", stall, 1'b1);
`else
    chk("rst_stall", stall, 1'b0);
`endif
    chk("rst_dbg_rdy", dbg.dbg_rdy, 1'b0);
    chk("rst_dbg_rsp", dbg.dbg_rsp, 1'b0);
    chk("rst_dbg_rdt", dbg.dbg_rdt, 0);
    chk("rst_g_e_rd", g_e_rd, 1'b0);
    chk("rst_g_e_rs1", g_e_rs1, 1'b0);
    chk("rst_g_e_rs2", g_e_rs2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dbg.dbg_vld = 1'b0;
    core_idle();

`ifdef R5P_GPR_CTL_CLEAR_EN
    // Reset in the middle of the clear restarts it from address 0.
    clear_phase(10);
    rst = 1'b1;
    @(negedge clk);
    chk("midclr_g_e_rd", g_e_rd, 1'b0);
    chk("midclr_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    after_reset();

    // Debug write then read with the core idle.
    en0 = 1'b1;
    core_idle();
    dbg_op(1'b1, 5'd5, 32'hDEADBEEF);
    dbg_op(1'b0, 5'd5, '0);

    // Core write x7=1, debug write x7=2, then a debug read held off by the core on rs1 for 3 cycles.
    c_e_rd = 1'b1; c_a_rd = 5'd7; c_d_rd = 32'd1;
    tick(acc);
    core_idle();
    dbg_op(1'b1, 5'd7, 32'd2);
    dbg.dbg_vld = 1'b1;
    dbg.dbg_req.wr = 1'b0; dbg.dbg_req.adr = 5'd7;
    c_e_rs1 = 1'b1; c_a_rs1 = 5'd5;
    for (int i = 0; i < 3; i++) tick(acc);
    core_idle();
    tick(acc);
    dbg.dbg_vld = 1'b0;

    // Write port conflict: core wins and the held debug write lands one cycle later.
    dbg.dbg_vld = 1'b1;
    dbg.dbg_req.wr = 1'b1; dbg.dbg_req.adr = 5'd9; dbg.dbg_req.wdt = 32'hA5A5_0009;
    c_e_rd = 1'b1; c_a_rd = 5'd9; c_d_rd = 32'h0000_1111;
    tick(acc);
    core_idle();
    tick(acc);
    dbg.dbg_vld = 1'b0;
    dbg_op(1'b0, 5'd9, '0);

    // x0 honours en0 for debug writes.
    en0 = 1'b1;
    dbg_op(1'b1, 5'd0, 32'h0);
    en0 = 1'b0;
    dbg_op(1'b1, 5'd0, 32'h1234);
    dbg_op(1'b0, 5'd0, '0);
    en0 = 1'b1;
    dbg_op(1'b1, 5'd0, 32'h1234);
    dbg_op(1'b0, 5'd0, '0);
    tick(acc);

    // Reset right after a read accept drops the pending response.
    dbg.dbg_vld = 1'b1;
    dbg.dbg_req.wr = 1'b0; dbg.dbg_req.adr = 5'd5;
    @(negedge clk);
    chk("midacc_dbg_rdy", dbg.dbg_rdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    dbg.dbg_vld = 1'b0;
    @(negedge clk);
    chk("midacc_dbg_rsp", dbg.dbg_rsp, 1'b0);
    chk("midacc_dbg_rdt", dbg.dbg_rdt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    after_reset();

    // Random traffic with debug requests held until accepted.
    for (int n = 0; n < 400; n++) begin
      c_e_rs1 = 1'($urandom); c_e_rs2 = 1'($urandom); c_e_rd = ($urandom_range(0, 2) == 0);
      c_a_rs1 = AW'($urandom); c_a_rs2 = AW'($urandom); c_a_rd = AW'($urandom);
      c_d_rd = $urandom;
      en0 = ($urandom_range(0, 3) != 0);
      if (!dbg.dbg_vld && $urandom_range(0, 1) == 1) begin
        dbg.dbg_vld = 1'b1;
        dbg.dbg_req.wr = 1'($urandom); dbg.dbg_req.adr = AW'($urandom); dbg.dbg_req.wdt = $urandom;
      end
      tick(acc);
      if (acc) dbg.dbg_vld = 1'b0;
    end
    dbg.dbg_vld = 1'b0;
    core_idle();
    repeat (3) tick(acc);
    chk("sbq_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
